// File: rtl/mux3_rr_sched_if.sv
// Bundle of the three requester streams, the registered output stream and
// the mux select/status lines of the three-input burst scheduler.
// "master" is the scheduler's view and "slave" is the environment's view.
interface mux3_rr_sched_if #(
   parameter int DW = 8
);
   logic          in0_valid;
   logic          in1_valid;
   logic          in2_valid;
   logic [DW-1:0] in0_data;
   logic [DW-1:0] in1_data;
   logic [DW-1:0] in2_data;
   logic          in0_last;
   logic          in1_last;
   logic          in2_last;
   logic          in0_ready;
   logic          in1_ready;
   logic          in2_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_ready;
   logic          sel1;
   logic          sel2;
   logic          busy;

   modport master (
      input  in0_valid, in1_valid, in2_valid,
      input  in0_data, in1_data, in2_data,
      input  in0_last, in1_last, in2_last,
      input  out_ready,
      output in0_ready, in1_ready, in2_ready,
      output out_valid, out_data, out_last,
      output sel1, sel2, busy
   );

   modport slave (
      output in0_valid, in1_valid, in2_valid,
      output in0_data, in1_data, in2_data,
      output in0_last, in1_last, in2_last,
      output out_ready,
      input  in0_ready, in1_ready, in2_ready,
      input  out_valid, out_data, out_last,
      input  sel1, sel2, busy
   );
endinterface

// File: rtl/mux3_rr_sched.sv
// Burst scheduler for a shared 3-input mux: round-robin arbitration in IDLE,
// grant held for a whole burst (closed by last or after MAX_BURST beats),
// select code (sel1,sel2) for the downstream mux, one registered output stage.
// Optional build macro MUX3_SCHED_FIXED_PRIO_EN: fixed priority in0 > in1 > in2
// instead of round-robin (the round-robin pointer is then never advanced).
module mux3_rr_sched #(
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mux3_rr_sched_if.master   bus
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

   state_t          state;
   logic [1:0]      grant;
   logic [1:0]      rr_ptr;
   logic [7:0]      beat_cnt;
   logic            sel_hi;
   logic            sel_lo;

   logic            stage_valid_p0;
   logic [DW-1:0]   stage_data_p0;
   logic            stage_last_p0;

   logic [2:0]      req;
   logic [2:0]      pick;
   logic            g_valid;
   logic [DW-1:0]   g_data;
   logic            g_last;
   logic            take;
   logic            accept;
   logic            cnt_full;
   logic            close;

   // First set request found scanning upward from ptr, modulo 3.
   // Returns {found, index}; the k=0 candidate is written last so it wins.
   function automatic logic [2:0] rr_pick(input logic [2:0] req_v, input logic [1:0] ptr);
      logic [2:0] res;
      logic [2:0] sum;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 2; k >= 0; k--) begin
         sum = {1'b0, ptr} + 3'(k);
         idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : 2'(sum);
         if (req_v[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   // Next round-robin start: one past the requester that just finished.
   function automatic logic [1:0] next_ptr(input logic [1:0] g);
      return (g == 2'd2) ? 2'd0 : g + 2'd1;
   endfunction

   assign req  = {bus.in2_valid, bus.in1_valid, bus.in0_valid};
   // In fixed-priority builds rr_ptr never leaves 0, so the scan is in0 > in1 > in2.
   assign pick = rr_pick(req, rr_ptr);

   // Route the granted requester's stream onto the shared beat path.
   always_comb begin
      g_valid = 1'b0;
      g_data  = '0;
      g_last  = 1'b0;
      unique case (grant)
         2'd0: begin
            g_valid = bus.in0_valid;
            g_data  = bus.in0_data;
            g_last  = bus.in0_last;
         end
         2'd1: begin
            g_valid = bus.in1_valid;
            g_data  = bus.in1_data;
            g_last  = bus.in1_last;
         end
         default: begin
            g_valid = bus.in2_valid;
            g_data  = bus.in2_data;
            g_last  = bus.in2_last;
         end
      endcase
   end

   assign take     = (state == GRANT) && (!stage_valid_p0 || bus.out_ready);
   assign accept   = take && g_valid;
   assign cnt_full = (beat_cnt == LAST_CNT);
   assign close    = accept && (g_last || cnt_full);

   assign bus.in0_ready = take && (grant == 2'd0);
   assign bus.in1_ready = take && (grant == 2'd1);
   assign bus.in2_ready = take && (grant == 2'd2);

   assign bus.out_valid = stage_valid_p0;
   assign bus.out_data  = stage_data_p0;
   assign bus.out_last  = stage_last_p0;
   assign bus.sel1      = sel_hi;
   assign bus.sel2      = sel_lo;
   assign bus.busy      = (state == GRANT);

   // Arbitration / burst-hold FSM; select code is only updated on IDLE->GRANT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant    <= 2'd0;
         rr_ptr   <= 2'd0;
         beat_cnt <= 8'd0;
         sel_hi   <= 1'b0;
         sel_lo   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick[2]) begin
                  state  <= GRANT;
                  grant  <= pick[1:0];
                  sel_hi <= (pick[1:0] != 2'd2);
                  sel_lo <= (pick[1:0] == 2'd0);
               end
            end
            GRANT: begin
               if (close) begin
                  state    <= IDLE;
                  beat_cnt <= 8'd0;
`ifndef MUX3_SCHED_FIXED_PRIO_EN
                  rr_ptr   <= next_ptr(grant);
`endif
               end else if (accept) begin
                  beat_cnt <= beat_cnt + 8'd1;
               end
            end
         endcase
      end
   end

   // Output stage p0: load on accept (forced last on the MAX_BURST beat), drain on out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_valid_p0 <= 1'b0;
         stage_data_p0  <= '0;
         stage_last_p0  <= 1'b0;
      end else if (accept) begin
         stage_valid_p0 <= 1'b1;
         stage_data_p0  <= g_data;
         stage_last_p0  <= g_last || cnt_full;
      end else if (bus.out_ready) begin
         stage_valid_p0 <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux3_rr_sched.sv
// Directed bench for mux3_rr_sched: queue-driven requesters, negedge monitor
// capturing grant order and output beats, compared against hand-written lists.
module tb_mux3_rr_sched;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_bad;

   mux3_rr_sched_if #(.DW(8)) bus ();

   mux3_rr_sched #(.DW(8), .MAX_BURST(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // source queues: {last, data}
   logic [8:0] sq0[$];
   logic [8:0] sq1[$];
   logic [8:0] sq2[$];
   logic [2:0] pause;

   // captures and expectations
   int         gq[$];
   logic [8:0] oq[$];
   int         eg[$];
   logic [8:0] eo[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, obs, exp_v);
      end
   endtask

   // requester driver: pop on handshake at posedge, present head #1 later
   initial begin
      bus.in0_valid = 1'b0; bus.in1_valid = 1'b0; bus.in2_valid = 1'b0;
      bus.in0_data  = '0;   bus.in1_data  = '0;   bus.in2_data  = '0;
      bus.in0_last  = 1'b0; bus.in1_last  = 1'b0; bus.in2_last  = 1'b0;
      forever begin
         @(posedge clk);
         if (bus.in0_valid && bus.in0_ready && sq0.size() > 0) void'(sq0.pop_front());
         if (bus.in1_valid && bus.in1_ready && sq1.size() > 0) void'(sq1.pop_front());
         if (bus.in2_valid && bus.in2_ready && sq2.size() > 0) void'(sq2.pop_front());
         #1;
         bus.in0_valid = (sq0.size() > 0) && !pause[0];
         bus.in1_valid = (sq1.size() > 0) && !pause[1];
         bus.in2_valid = (sq2.size() > 0) && !pause[2];
         if (sq0.size() > 0) begin bus.in0_data = sq0[0][7:0]; bus.in0_last = sq0[0][8]; end
         if (sq1.size() > 0) begin bus.in1_data = sq1[0][7:0]; bus.in1_last = sq1[0][8]; end
         if (sq2.size() > 0) begin bus.in2_data = sq2[0][7:0]; bus.in2_last = sq2[0][8]; end
      end
   end

   // monitor: grant starts, output transfers, 1-cycle acceptance-to-output latency
   initial begin
      logic       busy_d;
      logic       pend;
      logic [7:0] pend_data;
      busy_d = 1'b0;
      pend   = 1'b0;
      pend_data = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_d = 1'b0;
            pend   = 1'b0;
         end else begin
            if (pend) begin
               chk("lat_valid", 32'(bus.out_valid), 32'(1));
               chk("lat_data", 32'(bus.out_data), 32'(pend_data));
               pend = 1'b0;
            end
            if (bus.busy && !busy_d) gq.push_back(bus.sel1 ? (bus.sel2 ? 0 : 1) : 2);
            busy_d = bus.busy;
            if (bus.out_valid && bus.out_ready) oq.push_back({bus.out_last, bus.out_data});
            if (bus.in0_valid && bus.in0_ready) begin pend = 1'b1; pend_data = bus.in0_data; end
            if (bus.in1_valid && bus.in1_ready) begin pend = 1'b1; pend_data = bus.in1_data; end
            if (bus.in2_valid && bus.in2_ready) begin pend = 1'b1; pend_data = bus.in2_data; end
         end
      end
   end

   task automatic wait_busy(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.busy && n < 50);
      chk({tag, "_grant_seen"}, 32'(bus.busy), 32'(1));
   endtask

   task automatic wait_idle(input string tag);
      int   n;
      logic done;
      n = 0;
      done = 1'b0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
         done = (sq0.size() == 0) && (sq1.size() == 0) && (sq2.size() == 0)
                && !bus.busy && !bus.out_valid;
      end
      chk({tag, "_drained"}, 32'(done), 32'(1));
   endtask

   task automatic check_caps(input string tag);
      chk({tag, "_ngrants"}, 32'(gq.size()), 32'(eg.size()));
      for (int i = 0; i < eg.size() && i < gq.size(); i++)
         chk($sformatf("%s_grant%0d", tag, i), 32'(gq[i]), 32'(eg[i]));
      chk({tag, "_nbeats"}, 32'(oq.size()), 32'(eo.size()));
      for (int i = 0; i < eo.size() && i < oq.size(); i++)
         chk($sformatf("%s_beat%0d", tag, i), 32'(oq[i]), 32'(eo[i]));
      gq.delete();
      oq.delete();
   endtask

   initial begin
      n_chk = 0;
      n_bad = 0;
      pause = 3'b000;
      rst_n = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
      chk("rst_out_data", 32'(bus.out_data), 32'(0));
      chk("rst_out_last", 32'(bus.out_last), 32'(0));
      chk("rst_sel1", 32'(bus.sel1), 32'(0));
      chk("rst_sel2", 32'(bus.sel2), 32'(0));
      chk("rst_busy", 32'(bus.busy), 32'(0));
      chk("rst_in0_ready", 32'(bus.in0_ready), 32'(0));
      chk("rst_in1_ready", 32'(bus.in1_ready), 32'(0));
      chk("rst_in2_ready", 32'(bus.in2_ready), 32'(0));
      rst_n = 1'b1;

      // T1: all requesters with single-beat bursts
      @(negedge clk);
      bus.out_ready = 1'b1;
      sq0.push_back(9'h110); sq0.push_back(9'h113);
      sq1.push_back(9'h121);
      sq2.push_back(9'h132);
      wait_idle("t1");
`ifdef MUX3_SCHED_FIXED_PRIO_EN
      eg = '{0, 0, 1, 2};
      eo = '{9'h110, 9'h113, 9'h121, 9'h132};
`else
      eg = '{0, 1, 2, 0};
      eo = '{9'h110, 9'h121, 9'h132, 9'h113};
`endif
      check_caps("t1");

      // T2: in1 six beats, MAX_BURST=4 forces a close on beat 4
      sq1.push_back(9'h041); sq1.push_back(9'h042); sq1.push_back(9'h043);
      sq1.push_back(9'h044); sq1.push_back(9'h045); sq1.push_back(9'h146);
      wait_idle("t2");
      eg = '{1, 1};
      eo = '{9'h041, 9'h042, 9'h043, 9'h144, 9'h045, 9'h146};
      check_caps("t2");

      // T3: downstream stall for 3 cycles during an in0 burst
      bus.out_ready = 1'b0;
      sq0.push_back(9'h051); sq0.push_back(9'h052); sq0.push_back(9'h153);
      wait_busy("t3");
      chk("t3_sel1", 32'(bus.sel1), 32'(1));
      chk("t3_sel2", 32'(bus.sel2), 32'(1));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("t3_stall_ready%0d", i), 32'(bus.in0_ready), 32'(0));
         chk($sformatf("t3_stall_valid%0d", i), 32'(bus.out_valid), 32'(1));
         chk($sformatf("t3_stall_data%0d", i), 32'(bus.out_data), 32'(8'h51));
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      wait_idle("t3");
      eg = '{0};
      eo = '{9'h051, 9'h052, 9'h153};
      check_caps("t3");

      // T4: in2 burst with valid dropped 2 cycles while in0 waits
      sq2.push_back(9'h071); sq2.push_back(9'h072); sq2.push_back(9'h173);
      wait_busy("t4");
      chk("t4_sel1", 32'(bus.sel1), 32'(0));
      sq0.push_back(9'h161);
      pause[2] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("t4_hold_busy%0d", i), 32'(bus.busy), 32'(1));
         chk($sformatf("t4_hold_in0_ready%0d", i), 32'(bus.in0_ready), 32'(0));
         chk($sformatf("t4_hold_sel1_%0d", i), 32'(bus.sel1), 32'(0));
      end
      pause[2] = 1'b0;
      wait_idle("t4");
      eg = '{2, 0};
      eo = '{9'h071, 9'h072, 9'h173, 9'h161};
      check_caps("t4");

      // T5: asynchronous reset in the middle of an in1 burst
      sq1.push_back(9'h081); sq1.push_back(9'h082); sq1.push_back(9'h083); sq1.push_back(9'h184);
      wait_busy("t5");
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_out_valid", 32'(bus.out_valid), 32'(0));
      chk("t5_rst_busy", 32'(bus.busy), 32'(0));
      chk("t5_rst_sel1", 32'(bus.sel1), 32'(0));
      chk("t5_rst_sel2", 32'(bus.sel2), 32'(0));
      chk("t5_rst_in1_ready", 32'(bus.in1_ready), 32'(0));
      sq0.delete(); sq1.delete(); sq2.delete();
      gq.delete(); oq.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sq0.push_back(9'h191);
      sq1.push_back(9'h192);
      sq2.push_back(9'h193);
      wait_idle("t5");
      eg = '{0, 1, 2};
      eo = '{9'h191, 9'h192, 9'h193};
      check_caps("t5");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
